// File: rtl/alu_op_pkg.sv
// Shared types for the ALU control interface: control codes, opcodes,
// operand-A selects and the decoded-entry record carried through the issue stage.
package alu_op_pkg;

    typedef enum logic [5:0] {
        ALU_ADD    = 6'd0,
        ALU_SLL    = 6'd1,
        ALU_SLT    = 6'd2,
        ALU_SLTU   = 6'd3,
        ALU_XOR    = 6'd4,
        ALU_SRL    = 6'd5,
        ALU_OR     = 6'd6,
        ALU_AND    = 6'd7,
        ALU_SUB    = 6'd8,
        ALU_SRA    = 6'd13,
        ALU_BEQ    = 6'd16,
        ALU_BNE    = 6'd17,
        ALU_BLT    = 6'd20,
        ALU_BGE    = 6'd21,
        ALU_BLTU   = 6'd22,
        ALU_BGEU   = 6'd23,
        ALU_MUL    = 6'd24,
        ALU_MULH   = 6'd25,
        ALU_MULHSU = 6'd26,
        ALU_MULHU  = 6'd27,
        ALU_DIV    = 6'd28,
        ALU_DIVU   = 6'd29,
        ALU_REM    = 6'd30,
        ALU_REMU   = 6'd31,
        ALU_PASS_A = 6'd63
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_PC4  = 2'd2,
        OPA_ZERO = 2'd3
    } op_a_sel_e;

    // Immediate is kept at 32 bits here; the issue stage sign-extends to DataWidth.
    typedef struct packed {
        alu_op_e     alu_ctrl;
        op_a_sel_e   op_a_sel;
        logic        op_b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_we;
        logic        is_branch;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic        illegal;
    } dec_entry_t;

    // Turn an entry into the canonical illegal form: no ALU work, no side effects.
    function automatic dec_entry_t mark_illegal(input dec_entry_t e);
        dec_entry_t r;
        r           = e;
        r.alu_ctrl  = ALU_ADD;
        r.op_a_sel  = OPA_RS1;
        r.op_b_sel  = 1'b0;
        r.imm       = '0;
        r.reg_we    = 1'b0;
        r.is_branch = 1'b0;
        r.is_jump   = 1'b0;
        r.is_load   = 1'b0;
        r.is_store  = 1'b0;
        r.illegal   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/alu_op_encoder.sv
// Combinational RV32I(M) decoder: instruction word -> decoded ALU entry.
// Optional feature macro: MULDIV_EN (funct7==0x01 R-type decodes to codes 24..31).
module alu_op_encoder
    import alu_op_pkg::*;
(
    input  logic [31:0] instr,
    output dec_entry_t  entry
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Decode opcode/funct fields into control code, operand selects and class flags.
    always_comb begin
        dec_entry_t e;
        logic       bad;
        logic       we;
        e          = '0;
        e.alu_ctrl = ALU_ADD;
        e.op_a_sel = OPA_RS1;
        e.rs1      = instr[19:15];
        e.rs2      = instr[24:20];
        e.rd       = instr[11:7];
        bad        = 1'b0;
        we         = 1'b0;
        case (opc)
            OPC_OP: begin
                we = 1'b1;
                if (f7 == 7'h00) begin
                    e.alu_ctrl = alu_op_e'({3'b000, f3});
                end else if (f7 == 7'h20) begin
                    e.alu_ctrl = alu_op_e'({3'b001, f3});
                    bad        = !(f3 == 3'd0 || f3 == 3'd5);
                end else if (f7 == 7'h01) begin
`ifdef MULDIV_EN
                    e.alu_ctrl = alu_op_e'({3'b011, f3});
`else
                    bad = 1'b1;
`endif
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OPIMM: begin
                we         = 1'b1;
                e.op_b_sel = 1'b1;
                e.imm      = imm_i;
                if (f3 == 3'd1) begin
                    // Shifts carry only the 5-bit shamt as the operand.
                    e.imm      = {27'd0, instr[24:20]};
                    e.alu_ctrl = ALU_SLL;
                    bad        = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    e.imm      = {27'd0, instr[24:20]};
                    e.alu_ctrl = alu_op_e'({2'b00, f7[5], f3});
                    bad        = !(f7 == 7'h00 || f7 == 7'h20);
                end else begin
                    e.alu_ctrl = alu_op_e'({3'b000, f3});
                end
            end
            OPC_BRANCH: begin
                e.alu_ctrl  = alu_op_e'({3'b010, f3});
                e.imm       = imm_b;
                e.is_branch = 1'b1;
                bad         = (f3 == 3'd2 || f3 == 3'd3);
            end
            OPC_JAL: begin
                we         = 1'b1;
                e.alu_ctrl = ALU_PASS_A;
                e.op_a_sel = OPA_PC4;
                e.imm      = imm_j;
                e.is_jump  = 1'b1;
            end
            OPC_JALR: begin
                we         = 1'b1;
                e.alu_ctrl = ALU_PASS_A;
                e.op_a_sel = OPA_PC4;
                e.imm      = imm_i;
                e.is_jump  = 1'b1;
            end
            OPC_LUI: begin
                we         = 1'b1;
                e.op_a_sel = OPA_ZERO;
                e.op_b_sel = 1'b1;
                e.imm      = imm_u;
            end
            OPC_AUIPC: begin
                we         = 1'b1;
                e.op_a_sel = OPA_PC;
                e.op_b_sel = 1'b1;
                e.imm      = imm_u;
            end
            OPC_LOAD: begin
                we         = 1'b1;
                e.op_b_sel = 1'b1;
                e.imm      = imm_i;
                e.is_load  = 1'b1;
            end
            OPC_STORE: begin
                e.op_b_sel = 1'b1;
                e.imm      = imm_s;
                e.is_store = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // x0 is never written.
        e.reg_we = we && (e.rd != 5'd0);
        entry    = bad ? mark_illegal(e) : e;
    end

endmodule

// File: rtl/alu_op_issue.sv
// Decode/issue stage: valid/ready on both sides with an output register plus
// one skid register, so one instruction per clock is sustained under backpressure.
// Optional feature macro: MULDIV_EN (handled in alu_op_encoder).
module alu_op_issue
    import alu_op_pkg::*;
#(
    parameter int unsigned DataWidth = 32  // must be >= 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [DataWidth-1:0] in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           alu_ctrl,
    output logic [1:0]           op_a_sel,
    output logic                 op_b_sel,
    output logic [DataWidth-1:0] imm,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic                 reg_we,
    output logic                 is_branch,
    output logic                 is_jump,
    output logic                 is_load,
    output logic                 is_store,
    output logic                 illegal,
    output logic [DataWidth-1:0] out_pc
);

    dec_entry_t           dec;
    dec_entry_t           out_q, out_d, skid_q, skid_d;
    logic [DataWidth-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic                 out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 accept, drain;

    alu_op_encoder u_enc (
        .instr (in_instr),
        .entry (dec)
    );

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Next-state for the two-entry FIFO; flush wins over accept and drain.
    always_comb begin
        out_d        = out_q;
        out_pc_d     = out_pc_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so only the skid->output move can happen.
            if (drain) begin
                out_d        = skid_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || drain) begin
            out_valid_d = accept;
            if (accept) begin
                out_d    = dec;
                out_pc_d = in_pc;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_pc_d    = in_pc;
            skid_valid_d = 1'b1;
        end
        // Registered so in_ready has no combinational path from out_ready.
        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous reset; reset also covers a concurrent flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_pc_q     <= '0;
            skid_pc_q    <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_pc_q     <= out_pc_d;
            skid_pc_q    <= skid_pc_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_ctrl  = out_q.alu_ctrl;
    assign op_a_sel  = out_q.op_a_sel;
    assign op_b_sel  = out_q.op_b_sel;
    assign imm       = DataWidth'($signed(out_q.imm));
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign rd        = out_q.rd;
    assign reg_we    = out_q.reg_we;
    assign is_branch = out_q.is_branch;
    assign is_jump   = out_q.is_jump;
    assign is_load   = out_q.is_load;
    assign is_store  = out_q.is_store;
    assign illegal   = out_q.illegal;
    assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: vector table streamed through a
// scoreboard, plus backpressure, flush and reset sequences.
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, imm, out_pc;
    logic [5:0]  alu_ctrl;
    logic [1:0]  op_a_sel;
    logic        op_b_sel, reg_we, is_branch, is_jump, is_load, is_store, illegal;
    logic [4:0]  rs1, rs2, rd;

    alu_op_issue #(.DataWidth(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a_sel  (op_a_sel),
        .op_b_sel  (op_b_sel),
        .imm       (imm),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_we    (reg_we),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .is_load   (is_load),
        .is_store  (is_store),
        .illegal   (illegal),
        .out_pc    (out_pc)
    );

    always #5 clk = ~clk;

    // care bits: [4] rs1, [3] rs2, [2] rd, [1] imm, [0] op_b_sel
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  ctrl;
        logic [1:0]  asel;
        logic        bsel;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [3:0]  cls;  // {branch, jump, load, store}
        logic        ill;
        logic [4:0]  care;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];
    vec_t sbq[$];
    vec_t cur, e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_acc, first_fire, last_fire, nfire;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [5:0] ctrl, input logic [1:0] asel,
                                input logic bsel, input logic [31:0] im,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rdd, input logic we,
                                input logic [3:0] cls, input logic ill,
                                input logic [4:0] care);
        vec_t v;
        v.instr = instr; v.pc = pc; v.ctrl = ctrl; v.asel = asel; v.bsel = bsel;
        v.imm = im; v.rs1 = r1; v.rs2 = r2; v.rd = rdd; v.we = we; v.cls = cls;
        v.ill = ill; v.care = care;
        return v;
    endfunction

    // Scoreboard: pop/compare on output transfer, push on input handshake.
    always @(negedge clk) begin
        if (reset || flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                nfire++;
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("alu_ctrl[%08h]", e.instr), 32'(alu_ctrl), 32'(e.ctrl));
                    chk($sformatf("illegal[%08h]", e.instr), 32'(illegal), 32'(e.ill));
                    chk($sformatf("reg_we[%08h]", e.instr), 32'(reg_we), 32'(e.we));
                    chk($sformatf("class[%08h]", e.instr),
                        32'({is_branch, is_jump, is_load, is_store}), 32'(e.cls));
                    chk($sformatf("out_pc[%08h]", e.instr), out_pc, e.pc);
                    if (!e.ill)
                        chk($sformatf("op_a_sel[%08h]", e.instr), 32'(op_a_sel), 32'(e.asel));
                    if (e.care[4]) chk($sformatf("rs1[%08h]", e.instr), 32'(rs1), 32'(e.rs1));
                    if (e.care[3]) chk($sformatf("rs2[%08h]", e.instr), 32'(rs2), 32'(e.rs2));
                    if (e.care[2]) chk($sformatf("rd[%08h]", e.instr), 32'(rd), 32'(e.rd));
                    if (e.care[1]) chk($sformatf("imm[%08h]", e.instr), imm, e.imm);
                    if (e.care[0])
                        chk($sformatf("op_b_sel[%08h]", e.instr), 32'(op_b_sel), 32'(e.bsel));
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back(cur);
                if (first_acc < 0) first_acc = cyc;
            end
        end
    end

    // Present one instruction and hold it until it handshakes (bounded).
    task automatic send(input vec_t v);
        bit acc = 0;
        cur = v; in_instr = v.instr; in_pc = v.pc; in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain_wait();
        for (int k = 0; k < 100 && sbq.size() > 0; k++) @(posedge clk);
        if (sbq.size() > 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(32'h002081B3, 32'h1000, 6'd0,  2'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 4'b0000, 1'b0, 5'b11101);
        vecs[1]  = mk(32'h402081B3, 32'h1004, 6'd8,  2'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 4'b0000, 1'b0, 5'b11101);
        vecs[2]  = mk(32'h40335293, 32'h1008, 6'd13, 2'd0, 1'b1, 32'd3, 5'd6, 5'd0, 5'd5, 1'b1, 4'b0000, 1'b0, 5'b10111);
        vecs[3]  = mk(32'h00208863, 32'h100C, 6'd16, 2'd0, 1'b0, 32'd16, 5'd1, 5'd2, 5'd0, 1'b0, 4'b1000, 1'b0, 5'b11011);
        vecs[4]  = mk(32'h008000EF, 32'h0100, 6'd63, 2'd2, 1'b0, 32'd8, 5'd0, 5'd0, 5'd1, 1'b1, 4'b0100, 1'b0, 5'b00110);
`ifdef MULDIV_EN
        vecs[5]  = mk(32'h022081B3, 32'h1014, 6'd24, 2'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 4'b0000, 1'b0, 5'b11101);
`else
        vecs[5]  = mk(32'h022081B3, 32'h1014, 6'd0,  2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 5'b00000);
`endif
        vecs[6]  = mk(32'h00000000, 32'h1018, 6'd0,  2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 5'b00000);
        vecs[7]  = mk(32'h00000013, 32'h101C, 6'd0,  2'd0, 1'b1, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 5'b10111);
        vecs[8]  = mk(32'h123452B7, 32'h1020, 6'd0,  2'd3, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd5, 1'b1, 4'b0000, 1'b0, 5'b00111);
        vecs[9]  = mk(32'hFFC12083, 32'h1024, 6'd0,  2'd0, 1'b1, 32'hFFFFFFFC, 5'd2, 5'd0, 5'd1, 1'b1, 4'b0010, 1'b0, 5'b10111);
        vecs[10] = mk(32'h00112423, 32'h1028, 6'd0,  2'd0, 1'b1, 32'd8, 5'd2, 5'd1, 5'd0, 1'b0, 4'b0001, 1'b0, 5'b11011);
        vecs[11] = mk(32'h00001517, 32'h102C, 6'd0,  2'd1, 1'b1, 32'h1000, 5'd0, 5'd0, 5'd10, 1'b1, 4'b0000, 1'b0, 5'b00111);
        vecs[12] = mk(32'h402091B3, 32'h1030, 6'd0,  2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 5'b00000);
        vecs[13] = mk(32'h40209193, 32'h1034, 6'd0,  2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 5'b00000);
        vecs[14] = mk(32'h0020A863, 32'h1038, 6'd0,  2'd0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 5'b00000);
        vecs[15] = mk(32'hFFF34293, 32'h103C, 6'd4,  2'd0, 1'b1, 32'hFFFFFFFF, 5'd6, 5'd0, 5'd5, 1'b1, 4'b0000, 1'b0, 5'b10111);
        vecs[16] = mk(32'h00208033, 32'h1040, 6'd0,  2'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd0, 1'b0, 4'b0000, 1'b0, 5'b11101);
        vecs[17] = mk(32'hFE209EE3, 32'h1044, 6'd17, 2'd0, 1'b0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 1'b0, 4'b1000, 1'b0, 5'b11011);

        first_acc = -1; first_fire = -1; last_fire = -1; nfire = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; cur = vecs[0];

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Table stream with out_ready held high: 1-cycle latency, no bubbles
        out_ready = 1'b1;
        first_acc = -1; first_fire = -1; nfire = 0;
        for (int i = 0; i < NV; i++) send(vecs[i]);
        drain_wait();
        chk("latency", 32'(first_fire - first_acc), 32'd1);
        chk("no_bubble", 32'(last_fire - first_fire), 32'(NV - 1));
        chk("fire_count", 32'(nfire), 32'(NV));

        // Backpressure: A in output, B in skid, C stalled
        out_ready = 1'b0;
        send(vecs[2]);
        send(vecs[3]);
        cur = vecs[4]; in_instr = vecs[4].instr; in_pc = vecs[4].pc; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_stable_ctrl", 32'(alu_ctrl), 32'(vecs[2].ctrl));
            chk("bp_stable_imm", imm, vecs[2].imm);
            chk("bp_stable_pc", out_pc, vecs[2].pc);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(vecs[4]);
        drain_wait();

        // Flush with both entries full and an input presented
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        cur = vecs[4]; in_instr = vecs[4].instr; in_pc = vecs[4].pc;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_out_valid", 32'(out_valid), 32'd0);
        chk("flush_full_in_ready", 32'(in_ready), 32'd1);

        // Flush with one entry and an input that handshakes in the flush cycle
        @(posedge clk); #1;
        send(vecs[0]);
        cur = vecs[1]; in_instr = vecs[1].instr; in_pc = vecs[1].pc;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_hs_out_valid", 32'(out_valid), 32'd0);
        chk("flush_hs_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_no_stale", 32'(out_valid), 32'd0);
        end

        // Reset (with flush) mid-stream
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        cur = vecs[2]; in_instr = vecs[2].instr; in_pc = vecs[2].pc;
        in_valid = 1'b1; reset = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("mid_rst_imm", imm, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid_after", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(vecs[8]);
        drain_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
